jtag_bsr_chain: RTL and testbench
=================================

# jtag_bsr_chain

Parametrised boundary-scan register (BSR) for wrapping an arbitrary benchmark core with N_IN input cells and N_OUT output cells on a single TCLK domain. It is the generalised successor to the fixed per-circuit BSR wrappers. It adds three features:
- a 1-bit bypass register and an INTEST mode;
- a shift-length guard that blocks updates after a truncated or over-long shift;
- sticky protocol-error status.

The block sits between device pins and the core under test, and is driven by the TAP controller's DR strobes.

## Interface
Parameters:
- N_IN, 36: number of input boundary cells (chain positions 0..N_IN-1).
- N_OUT, 38: number of output boundary cells (positions N_IN..L-1, L = N_IN+N_OUT).
- LEN_CHECK, 1: 1 enables the shift-length update guard; 0 makes every update unconditional.

Ports:
- Clock and reset: one clock, TCLK; reset is asynchronous and active-high, TRST.
- TCLK  in  1  test clock; all state changes on the rising edge.
- TRST  in  1  asynchronous active-high reset.
- inst  in  2  mode: 00 EXTEST, 01 SAMPLE/PRELOAD, 10 INTEST, 11 BYPASS.
- clockdr  in  1  capture strobe (one TCLK cycle).
- shiftdr  in  1  shift strobe; each asserted cycle shifts one bit.
- updatedr  in  1  update strobe (one TCLK cycle).
- err_clr  in  1  synchronous clear of len_err and proto_err.
- TDI  in  1  serial in.
- TDO  out  1  serial out. Source is cell L-1, or the bypass bit when inst=11. Combinational from registers.
- pin_in  in  N_IN  device input pins.
- core_in  out  N_IN  to core. INTEST: update-input bits. Otherwise: pin_in.
- core_out  in  N_OUT  from core.
- pin_out  out  N_OUT  device output pins. EXTEST/INTEST: update-output bits. Otherwise: core_out.
- shift_cnt  out  CW  shifts since the last capture or update. CW = clog2(L+1)+1. Saturates at all-ones.
- len_err  out  1  sticky: an update was blocked by the guard.
- proto_err  out  1  sticky: more than one strobe was asserted in a cycle.

## Operation
- State: shift chain sc[L-1:0], update register ur[L-1:0], bypass bit byp, counter, two error flags.
- Strobe decode per cycle: exactly one of clockdr/shiftdr/updatedr asserted means that action is taken. Zero asserted means hold. Two or more asserted means no action and proto_err is set.
- Capture, inst≠11:
  - sc[i] ← pin_in[i] for i<N_IN;
  - sc[N_IN+j] ← core_out[j];
  - shift_cnt ← 0.
- Capture, inst=11: byp ← 0. shift_cnt is unchanged.
- Shift, inst≠11:
  - sc[0] ← TDI; sc[k] ← sc[k-1];
  - shift_cnt increments (saturating).
- Shift, inst=11: byp ← TDI. sc and shift_cnt are unchanged.
- Update, inst≠11: if LEN_CHECK=0 or shift_cnt==L, then ur ← sc. Otherwise ur holds and len_err is set. In both cases shift_cnt ← 0.
- Update, inst=11: no effect.
- Changing inst never alters sc, ur or byp; only the output muxes and the TDO source switch.
- err_clr clears both flags. If an error event occurs in the same cycle as err_clr, the flag sets, because set wins.
- Reset: sc, ur, byp, shift_cnt, len_err and proto_err are all cleared to 0.
  - TDO=0.
  - pin_out/core_in follow the mode mux: ur=0 in EXTEST/INTEST, transparent otherwise.

## Timing
- Capture: sc reflects pin_in/core_out sampled at the strobe edge; TDO shows the captured cell L-1 in the following cycle.
- Shift: TDO changes in the cycle after each shift edge. A bit entering at TDI appears at TDO L cycles later (1 cycle in BYPASS).
- Update: pin_out/core_in change in the cycle after the update edge (1-cycle latency).
- Mode mux: combinational, with zero-cycle effect on pin_out/core_in/TDO.
- shift_cnt saturation: stays at all-ones, so an update after an over-long shift is always blocked when LEN_CHECK=1.
- TRST asserted mid-shift: all state clears immediately, without waiting for a clock. The first edge after TRST deasserts acts normally.

## Test plan
All scenarios use N_IN=4, N_OUT=3, L=7, LEN_CHECK=1.
- Reset: TRST mid-shift with inst=00 → TDO=0, pin_out=3'b000, shift_cnt=0, flags 0, asynchronously.
- EXTEST preload/update: shift TDI=1,0,1,1,0,0,1 over 7 cycles, then update → pin_out=3'b101 next cycle. Switching to inst=10 → core_in=4'b1001.
- SAMPLE capture: pin_in=4'hA, core_out=3'b110, capture, then 7 shifts → TDO sequence 1,1,0,1,0,1,0 (first value before the first shift). pin_out tracks core_out throughout.
- Short shift: capture, 5 shifts, update → ur unchanged, len_err=1. err_clr → len_err=0.
- BYPASS: inst=11, shift 1,1,0 → TDO 1,1,0 each delayed one cycle. sc is unchanged; a subsequent update does nothing.
- Protocol error: clockdr and updatedr asserted together → proto_err=1, and sc, ur and shift_cnt are unchanged.

Source files
------------

// File: rtl/jtag_bsr_chain.sv
// Parametrised boundary-scan register: N_IN input cells and N_OUT output cells on one TCLK
// domain. Adds a bypass bit, INTEST, a shift-length update guard and sticky error status.
module jtag_bsr_chain #(
  parameter int N_IN      = 36,
  parameter int N_OUT     = 38,
  parameter int LEN_CHECK = 1,
  localparam int L        = N_IN + N_OUT,
  localparam int CW       = $clog2(L + 1) + 1
) (
  input  logic             TCLK,
  input  logic             TRST,
  input  logic [1:0]       inst,
  input  logic             clockdr,
  input  logic             shiftdr,
  input  logic             updatedr,
  input  logic             err_clr,
  input  logic             TDI,
  output logic             TDO,
  input  logic [N_IN-1:0]  pin_in,
  output logic [N_IN-1:0]  core_in,
  input  logic [N_OUT-1:0] core_out,
  output logic [N_OUT-1:0] pin_out,
  output logic [CW-1:0]    shift_cnt,
  output logic             len_err,
  output logic             proto_err
);

  localparam logic [1:0] INST_EXTEST = 2'b00;
  localparam logic [1:0] INST_SAMPLE = 2'b01;
  localparam logic [1:0] INST_INTEST = 2'b10;
  localparam logic [1:0] INST_BYPASS = 2'b11;

  localparam logic [CW-1:0] CNT_FULL = CW'(L);
  localparam logic [CW-1:0] CNT_SAT  = '1;

  logic [L-1:0] sc;
  logic [L-1:0] ur;
  logic         byp;

  logic [1:0] n_strobe;
  logic       one_strobe;
  logic       multi_strobe;
  logic       do_capture;
  logic       do_shift;
  logic       do_update;
  logic       byp_mode;
  logic       len_ok;
  logic       upd_blocked;

  // A cycle with more than one DR strobe is a TAP protocol violation: no action, flag only.
  assign n_strobe     = {1'b0, clockdr} + {1'b0, shiftdr} + {1'b0, updatedr};
  assign one_strobe   = (n_strobe == 2'd1);
  assign multi_strobe = (n_strobe >= 2'd2);

  assign do_capture = clockdr  & one_strobe;
  assign do_shift   = shiftdr  & one_strobe;
  assign do_update  = updatedr & one_strobe;

  assign byp_mode = (inst == INST_BYPASS);

  // The counter saturates, so an over-long shift can never alias back to exactly L.
  assign len_ok      = (LEN_CHECK == 0) || (shift_cnt == CNT_FULL);
  assign upd_blocked = do_update & ~byp_mode & ~len_ok;

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values; sc and ur are flop vectors, not memories, so resetting them is intended.
  always_ff @(posedge TCLK or posedge TRST) begin
    if (TRST) begin
      sc        <= '0;
      ur        <= '0;
      byp       <= 1'b0;
      shift_cnt <= '0;
    end else begin
      if (do_capture) begin
        if (byp_mode) begin
          byp <= 1'b0;
        end else begin
          sc        <= {core_out, pin_in};
          shift_cnt <= '0;
        end
      end

      if (do_shift) begin
        if (byp_mode) begin
          byp <= TDI;
        end else begin
          sc <= {sc[L-2:0], TDI};
          if (shift_cnt != CNT_SAT) begin
            shift_cnt <= shift_cnt + CW'(1);
          end
        end
      end

      if (do_update && !byp_mode) begin
        if (len_ok) begin
          ur <= sc;
        end
        shift_cnt <= '0;
      end
    end
  end

  // Set has priority over err_clr so an error in the clearing cycle is never lost.
  always_ff @(posedge TCLK or posedge TRST) begin
    if (TRST) begin
      len_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (upd_blocked) begin
        len_err <= 1'b1;
      end else if (err_clr) begin
        len_err <= 1'b0;
      end

      if (multi_strobe) begin
        proto_err <= 1'b1;
      end else if (err_clr) begin
        proto_err <= 1'b0;
      end
    end
  end

  assign TDO = byp_mode ? byp : sc[L-1];

  assign core_in = (inst == INST_INTEST) ? ur[N_IN-1:0] : pin_in;

  assign pin_out = ((inst == INST_EXTEST) || (inst == INST_INTEST)) ? ur[L-1:N_IN]
                                                                     : core_out;

  // SAMPLE/PRELOAD is the fully transparent mode; named here for the decode above.
  logic sample_mode;
  assign sample_mode = (inst == INST_SAMPLE);

  logic unused_ok;
  assign unused_ok = sample_mode;

endmodule

// File: tb/tb_jtag_bsr_chain.sv
// Directed self-checking bench for jtag_bsr_chain with N_IN=4, N_OUT=3 (L=7), LEN_CHECK=1.
module tb_jtag_bsr_chain;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int L     = N_IN + N_OUT;
  localparam int CW    = $clog2(L + 1) + 1;

  logic             TCLK;
  logic             TRST;
  logic [1:0]       inst;
  logic             clockdr;
  logic             shiftdr;
  logic             updatedr;
  logic             err_clr;
  logic             TDI;
  logic             TDO;
  logic [N_IN-1:0]  pin_in;
  logic [N_IN-1:0]  core_in;
  logic [N_OUT-1:0] core_out;
  logic [N_OUT-1:0] pin_out;
  logic [CW-1:0]    shift_cnt;
  logic             len_err;
  logic             proto_err;

  int n_checks = 0;
  int n_fails  = 0;

  jtag_bsr_chain #(.N_IN(N_IN), .N_OUT(N_OUT), .LEN_CHECK(1)) dut (
    .TCLK      (TCLK),
    .TRST      (TRST),
    .inst      (inst),
    .clockdr   (clockdr),
    .shiftdr   (shiftdr),
    .updatedr  (updatedr),
    .err_clr   (err_clr),
    .TDI       (TDI),
    .TDO       (TDO),
    .pin_in    (pin_in),
    .core_in   (core_in),
    .core_out  (core_out),
    .pin_out   (pin_out),
    .shift_cnt (shift_cnt),
    .len_err   (len_err),
    .proto_err (proto_err)
  );

  initial begin
    TCLK = 1'b0;
    forever #5 TCLK = ~TCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Called at a falling edge: drive strobes, let one rising edge pass, return at the next
  // falling edge with strobes released.
  task automatic step(input logic cd, input logic sd, input logic ud, input logic din,
                      input logic clr);
    clockdr  = cd;
    shiftdr  = sd;
    updatedr = ud;
    TDI      = din;
    err_clr  = clr;
    @(negedge TCLK);
    clockdr  = 1'b0;
    shiftdr  = 1'b0;
    updatedr = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic test_power_on;
    TRST = 1'b1; inst = 2'b00; clockdr = 0; shiftdr = 0; updatedr = 0;
    err_clr = 0; TDI = 0; pin_in = 4'h5; core_out = 3'b011;
    @(negedge TCLK);
    n_checks++;
    if (TDO !== 1'b0) begin n_fails++; $display("FAIL por_tdo: got %b want 0", TDO); end
    n_checks++;
    if (pin_out !== 3'b000) begin n_fails++; $display("FAIL por_pin_out: got %b want 000", pin_out); end
    n_checks++;
    if (core_in !== 4'h5) begin n_fails++; $display("FAIL por_core_in: got %h want 5", core_in); end
    n_checks++;
    if (shift_cnt !== 4'd0 || len_err !== 1'b0 || proto_err !== 1'b0) begin
      n_fails++;
      $display("FAIL por_cnt_flags: cnt=%0d len=%b proto=%b want 0/0/0", shift_cnt, len_err, proto_err);
    end
    TRST = 1'b0;
  endtask

  task automatic test_extest_preload;
    logic [6:0] bits;
    bits = 7'b1011001;  // bits[6] first in time: 1,0,1,1,0,0,1
    inst = 2'b00;
    for (int k = 6; k >= 0; k--) step(0, 1, 0, bits[k], 0);
    n_checks++;
    if (shift_cnt !== 4'd7) begin n_fails++; $display("FAIL extest_cnt: got %0d want 7", shift_cnt); end
    n_checks++;
    if (pin_out !== 3'b000) begin n_fails++; $display("FAIL extest_pre_update: got %b want 000", pin_out); end
    step(0, 0, 1, 0, 0);
    n_checks++;
    if (pin_out !== 3'b101) begin n_fails++; $display("FAIL extest_pin_out: got %b want 101", pin_out); end
    n_checks++;
    if (shift_cnt !== 4'd0 || len_err !== 1'b0) begin
      n_fails++; $display("FAIL extest_post: cnt=%0d len=%b want 0/0", shift_cnt, len_err);
    end
    inst = 2'b10;
    #1;
    n_checks++;
    if (core_in !== 4'b1001) begin n_fails++; $display("FAIL intest_core_in: got %b want 1001", core_in); end
    n_checks++;
    if (pin_out !== 3'b101) begin n_fails++; $display("FAIL intest_pin_out: got %b want 101", pin_out); end
    @(negedge TCLK);
  endtask

  task automatic test_sample;
    logic [6:0] exp_seq;
    exp_seq = 7'b1101010;
    inst = 2'b01; pin_in = 4'hA; core_out = 3'b110;
    step(1, 0, 0, 0, 0);
    n_checks++;
    if (TDO !== exp_seq[6]) begin n_fails++; $display("FAIL sample_tdo0: got %b want %b", TDO, exp_seq[6]); end
    n_checks++;
    if (pin_out !== 3'b110 || core_in !== 4'hA) begin
      n_fails++; $display("FAIL sample_transparent: pin_out=%b core_in=%h want 110/a", pin_out, core_in);
    end
    for (int k = 1; k < 7; k++) begin
      step(0, 1, 0, 0, 0);
      n_checks++;
      if (TDO !== exp_seq[6-k]) begin
        n_fails++; $display("FAIL sample_tdo%0d: got %b want %b", k, TDO, exp_seq[6-k]);
      end
    end
    step(0, 1, 0, 0, 0);
    core_out = 3'b001;
    #1;
    n_checks++;
    if (pin_out !== 3'b001) begin n_fails++; $display("FAIL sample_track: got %b want 001", pin_out); end
    n_checks++;
    if (shift_cnt !== 4'd7) begin n_fails++; $display("FAIL sample_cnt: got %0d want 7", shift_cnt); end
    @(negedge TCLK);
  endtask

  task automatic test_short_shift;
    inst = 2'b00; pin_in = 4'h0; core_out = 3'b000;
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 0);
    n_checks++;
    if (shift_cnt !== 4'd5) begin n_fails++; $display("FAIL short_cnt: got %0d want 5", shift_cnt); end
    step(0, 0, 1, 0, 0);
    n_checks++;
    if (len_err !== 1'b1) begin n_fails++; $display("FAIL short_len_err: got %b want 1", len_err); end
    n_checks++;
    if (pin_out !== 3'b101 || shift_cnt !== 4'd0) begin
      n_fails++; $display("FAIL short_ur_hold: pin_out=%b cnt=%0d want 101/0", pin_out, shift_cnt);
    end
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (len_err !== 1'b0) begin n_fails++; $display("FAIL short_clr: got %b want 0", len_err); end
  endtask

  task automatic test_saturation;
    inst = 2'b00;
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) step(0, 1, 0, 1, 0);
    n_checks++;
    if (shift_cnt !== 4'hF) begin n_fails++; $display("FAIL sat_cnt: got %0d want 15", shift_cnt); end
    step(0, 0, 1, 0, 0);
    n_checks++;
    if (len_err !== 1'b1 || pin_out !== 3'b101) begin
      n_fails++; $display("FAIL sat_blocked: len=%b pin_out=%b want 1/101", len_err, pin_out);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_bypass;
    inst = 2'b01; pin_in = 4'h0; core_out = 3'b110;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);  // sc[6] <= sc[5] = 1, cnt = 1
    inst = 2'b11;
    #1;
    n_checks++;
    if (TDO !== 1'b0) begin n_fails++; $display("FAIL byp_tdo_init: got %b want 0", TDO); end
    @(negedge TCLK);
    step(0, 1, 0, 1, 0);
    n_checks++;
    if (TDO !== 1'b1) begin n_fails++; $display("FAIL byp_tdo0: got %b want 1", TDO); end
    step(0, 1, 0, 1, 0);
    n_checks++;
    if (TDO !== 1'b1) begin n_fails++; $display("FAIL byp_tdo1: got %b want 1", TDO); end
    step(0, 1, 0, 0, 0);
    n_checks++;
    if (TDO !== 1'b0) begin n_fails++; $display("FAIL byp_tdo2: got %b want 0", TDO); end
    step(0, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    n_checks++;
    if (TDO !== 1'b0) begin n_fails++; $display("FAIL byp_capture: got %b want 0", TDO); end
    step(0, 0, 1, 0, 0);
    n_checks++;
    if (shift_cnt !== 4'd1) begin n_fails++; $display("FAIL byp_cnt: got %0d want 1", shift_cnt); end
    inst = 2'b01;
    #1;
    n_checks++;
    if (TDO !== 1'b1) begin n_fails++; $display("FAIL byp_sc_hold: got %b want 1", TDO); end
    inst = 2'b00;
    #1;
    n_checks++;
    if (pin_out !== 3'b101) begin n_fails++; $display("FAIL byp_ur_hold: got %b want 101", pin_out); end
    inst = 2'b01;
    @(negedge TCLK);
  endtask

  task automatic test_protocol;
    inst = 2'b01; core_out = 3'b000; pin_in = 4'hF;
    step(1, 0, 1, 0, 0);
    n_checks++;
    if (proto_err !== 1'b1) begin n_fails++; $display("FAIL proto_set: got %b want 1", proto_err); end
    n_checks++;
    if (shift_cnt !== 4'd1 || TDO !== 1'b1) begin
      n_fails++; $display("FAIL proto_no_action: cnt=%0d tdo=%b want 1/1", shift_cnt, TDO);
    end
    inst = 2'b00;
    #1;
    n_checks++;
    if (pin_out !== 3'b101 || len_err !== 1'b0) begin
      n_fails++; $display("FAIL proto_ur_hold: pin_out=%b len=%b want 101/0", pin_out, len_err);
    end
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (proto_err !== 1'b0) begin n_fails++; $display("FAIL proto_clr: got %b want 0", proto_err); end
    step(0, 1, 1, 0, 1);
    n_checks++;
    if (proto_err !== 1'b1 || shift_cnt !== 4'd1) begin
      n_fails++; $display("FAIL proto_set_wins: proto=%b cnt=%0d want 1/1", proto_err, shift_cnt);
    end
  endtask

  task automatic test_reset;
    inst = 2'b00;
    for (int k = 0; k < 7; k++) step(0, 1, 0, 1, 0);
    step(0, 0, 1, 1, 0);  // update with cnt=8 is blocked, sets len_err
    for (int k = 0; k < 3; k++) step(0, 1, 0, 1, 0);
    n_checks++;
    if (TDO !== 1'b1 || shift_cnt !== 4'd3 || len_err !== 1'b1 || proto_err !== 1'b1) begin
      n_fails++;
      $display("FAIL rst_pre: tdo=%b cnt=%0d len=%b proto=%b want 1/3/1/1", TDO, shift_cnt, len_err, proto_err);
    end
    shiftdr = 1'b1; TDI = 1'b1;
    #2 TRST = 1'b1;
    #1;
    n_checks++;
    if (TDO !== 1'b0 || pin_out !== 3'b000) begin
      n_fails++; $display("FAIL rst_async_out: tdo=%b pin_out=%b want 0/000", TDO, pin_out);
    end
    n_checks++;
    if (shift_cnt !== 4'd0 || len_err !== 1'b0 || proto_err !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_async_state: cnt=%0d len=%b proto=%b want 0/0/0", shift_cnt, len_err, proto_err);
    end
    @(negedge TCLK);
    TRST = 1'b0;
    step(0, 1, 0, 1, 0);
    n_checks++;
    if (shift_cnt !== 4'd1 || TDO !== 1'b0) begin
      n_fails++; $display("FAIL rst_first_edge: cnt=%0d tdo=%b want 1/0", shift_cnt, TDO);
    end
  endtask

  initial begin
    test_power_on();
    test_extest_preload();
    test_sample();
    test_short_shift();
    test_saturation();
    test_bypass();
    test_protocol();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
